// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem req/ack handshake, registered Instr/PCPLUS4.
// Optional FETCH_TIMEOUT_EN adds a REQ timeout counter and a sticky ERR state.
module fetch_stage #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] Result,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] PCPLUS4,
    output logic                  instr_valid,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
`ifdef FETCH_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4  = pc + DATA_WIDTH'(4);
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            Instr       <= '0;
            PCPLUS4     <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                REQ: begin
                    if (imem_ack) begin
                        Instr       <= imem_rdata;
                        PCPLUS4     <= pc_plus4;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (!stall) begin
                        // Redirect targets are forced to word alignment
                        pc          <= PCSrc ? (Result & ~DATA_WIDTH'(3))
                                             : pc_plus4;
                        instr_valid <= 1'b0;
                        state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ERR: state <= ERR;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-cycle-derived ARM datapath, sitting directly upstream of the register-file/extend stage. Holds the program counter, runs a request/acknowledge handshake with instruction memory, and presents a registered `Instr` and `PCPLUS4` to decode. It advances only when decode consumes the current instruction, and it takes a branch or PC-write redirect from the writeback `Result` bus.

## Interface
- `DATA_WIDTH`, 32: instruction and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `TIMEOUT_CYCLES`, 16: max cycles spent in REQ without ack; used only with `FETCH_TIMEOUT_EN`.

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; always equals the PC register.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  decode cannot consume the presented instruction this cycle.
- `PCSrc`  in  1  redirect request; sampled only on a consume cycle.
- `Result`  in  32  redirect target; sampled only when `PCSrc` is sampled high.
- `Instr`  out  32  registered instruction to decode.
- `PCPLUS4`  out  32  registered PC+4 of the instruction in `Instr`.
- `instr_valid`  out  1  `Instr` and `PCPLUS4` are valid.
- `fetch_err`  out  1  sticky fetch timeout flag.

## Operation
- States: IDLE, REQ, HOLD, and ERR (ERR exists only with `FETCH_TIMEOUT_EN`).
- Reset values: PC=`RESET_PC`; state=IDLE; `Instr`=0; `PCPLUS4`=0; `instr_valid`=0; `imem_req`=0; `fetch_err`=0; timeout counter=0.
- IDLE: `imem_req`=0. Moves unconditionally to REQ on the next clock.
- REQ: `imem_req`=1 and `imem_addr`=PC; the address is held stable until ack.
  - On `imem_ack`: `Instr`<=`imem_rdata`, `PCPLUS4`<=PC+4, `instr_valid`<=1, next state HOLD.
  - `imem_ack` is ignored whenever `imem_req`=0.
- HOLD: `imem_req`=0; `instr_valid`=1; outputs are frozen.
- Consume occurs when `instr_valid` && !`stall` in HOLD.
  - PC<=`PCSrc` ? {`Result`[31:2],2'b00} : PC+4.
  - `instr_valid`<=0; next state REQ.
- `stall` held high in HOLD keeps `Instr`, `PCPLUS4` and PC unchanged indefinitely.
- `PCSrc` and `Result` have no effect outside a consume cycle.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- A redirect target with nonzero bits [1:0] is silently word-aligned.
- Reset asserted mid-REQ drops `imem_req` asynchronously; a late ack after reset release is ignored because the FSM is in IDLE.

## Timing
- First `imem_req` rises in the cycle after the first clock edge following reset deassertion (IDLE lasts 1 cycle).
- Ack in cycle N: `instr_valid`=1 from cycle N+1.
- Consume in cycle M: `imem_req`=1 with the new PC in cycle M+1.
- Zero-wait memory (ack in the same cycle as req) gives a 2-cycle-per-instruction throughput.
- No combinational path from `stall`, `PCSrc` or `Result` to any output; `imem_req` and `imem_addr` depend only on registered state.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter increments every cycle in REQ without ack and clears on entry to REQ.
  - When the count reaches `TIMEOUT_CYCLES` without ack, the FSM enters ERR: `imem_req`=0, `instr_valid`=0, `fetch_err`=1.
  - ERR is left only by reset.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter and no ERR state; REQ waits forever.
  - `fetch_err` is tied to 0.

## Test plan
- Reset with `RESET_PC`=0, memory acks immediately, `stall`=0, `PCSrc`=0 -> `imem_addr` sequence 0, 4, 8, 12; `instr_valid` high every other cycle; `PCPLUS4`=4, 8, 12, 16.
- Memory ack delayed 3 cycles -> `imem_req`/`imem_addr` stable for 4 cycles; `Instr`=`imem_rdata` captured on the ack cycle; `instr_valid` rises the cycle after.
- `stall`=1 for 5 cycles in HOLD with `Instr`=32'hE3A01005 -> `Instr`, `PCPLUS4` and `instr_valid` unchanged and no request issued; release -> next request issued to PC+4.
- Consume with `PCSrc`=1 and `Result`=32'h0000_0103 -> next `imem_addr`=32'h0000_0100; `PCSrc` pulsed during REQ -> no effect.
- PC=32'hFFFF_FFFC consumed -> next `imem_addr`=0; reset asserted mid-REQ followed by a late ack -> outputs at reset values and `Instr` stays 0.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no ack -> `fetch_err`=1 after 16 REQ cycles, `imem_req`=0, held until reset; without the macro -> `imem_req` still high after 100 cycles and `fetch_err`=0.
